// File: rtl/arbiter_rr_4req.sv
// arbiter_rr_4req: round-robin arbiter for 4 requesters with a bounded hold time per grant
module arbiter_rr_4req #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       gnt_new
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t     state_q, state_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [1:0] last_q, last_d, gnt_idx_q, gnt_idx_d, win, cand;
    logic [3:0] gnt_q, gnt_d;
    logic       gnt_valid_q, gnt_valid_d, gnt_new_q, gnt_new_d, found, keep;
    always_comb begin
        found = 1'b0;
        win   = 2'd0;
        cand  = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        keep        = state_q == GRANT && req[gnt_idx_q] && hold_cnt_q < 8'(MAX_HOLD);
        state_d     = keep || found ? GRANT : IDLE;
        hold_cnt_d  = keep ? hold_cnt_q + 8'd1 : {7'd0, found};
        last_d      = !keep && found ? win : last_q;
        gnt_idx_d   = keep ? gnt_idx_q : found ? win : 2'd0;
        gnt_valid_d = keep || found;
        gnt_d       = gnt_valid_d ? 4'b0001 << gnt_idx_d : 4'b0000;
        gnt_new_d   = !keep && found;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_cnt_q  <= 8'd0;
            last_q      <= 2'd3;
            gnt_idx_q   <= 2'd0;
            gnt_q       <= 4'b0000;
            gnt_valid_q <= 1'b0;
            gnt_new_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            last_q      <= last_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_new_q   <= gnt_new_d;
        end
    end
    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_new   = gnt_new_q;
endmodule

// File: tb/tb_arbiter_rr_4req.sv
// tb_arbiter_rr_4req: directed vector table plus model-driven random traffic through a scoreboard
module tb_arbiter_rr_4req;
    localparam int MH = 4;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid, gnt_new;
    always #5 clk = ~clk;
    arbiter_rr_4req #(.MAX_HOLD(MH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .gnt_new(gnt_new)
    );
    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       v;
        logic       n;
    } exp_t;
    typedef struct {
        bit         pre_rst;
        logic [3:0] req;
        exp_t       e;
    } vec_t;
    exp_t exp_q[$];
    vec_t tbl[$];
    int   n_run = 0;
    int   n_fail = 0;
    int   m_owner, m_hold, m_last;
    function automatic exp_t own(int o, logic n);
        exp_t e;
        e.gnt = 4'(1 << o);
        e.idx = 2'(o);
        e.v   = 1'b1;
        e.n   = n;
        return e;
    endfunction
    function automatic void add(bit p, logic [3:0] r, exp_t e);
        vec_t v;
        v.pre_rst = p;
        v.req     = r;
        v.e       = e;
        tbl.push_back(v);
    endfunction
    task automatic check(input string name);
        exp_t e, a;
        logic inv;
        a = {gnt, gnt_idx, gnt_valid, gnt_new};
        n_run++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got gnt=%b idx=%0d v=%b new=%b", name, gnt, gnt_idx, gnt_valid, gnt_new);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got gnt=%b idx=%0d v=%b new=%b, want gnt=%b idx=%0d v=%b new=%b",
                         name, a.gnt, a.idx, a.v, a.n, e.gnt, e.idx, e.v, e.n);
            end
        end
        n_run++;
        inv = (gnt == 4'b0000 || $onehot(gnt)) && gnt_valid == |gnt && (!gnt_valid || gnt == 4'(1 << gnt_idx));
        if (inv !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_invariant: got gnt=%b idx=%0d v=%b, want consistent one-hot", name, gnt, gnt_idx, gnt_valid);
        end
    endtask
    task automatic cycle(input logic [3:0] r, input exp_t e, input string name);
        @(negedge clk);
        req = r;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check(name);
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b1111;
        repeat (2) begin
            exp_q.push_back('0);
            @(posedge clk);
            #1;
            check("reset");
        end
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b0000;
    endtask
    task automatic model(input logic [3:0] r, output exp_t e);
        int w;
        if (m_owner >= 0 && r[m_owner] && m_hold < MH) begin
            m_hold++;
            e = own(m_owner, 1'b0);
        end else begin
            w = -1;
            for (int k = 1; k <= 4; k++)
                if (w < 0 && r[(m_last + k) % 4]) w = (m_last + k) % 4;
            if (w >= 0) begin
                m_owner = w;
                m_last  = w;
                m_hold  = 1;
                e = own(w, 1'b1);
            end else begin
                m_owner = -1;
                m_hold  = 0;
                e = '0;
            end
        end
    endtask
    initial begin
        logic [3:0] r;
        exp_t       e;
        add(1, 4'b0100, own(2, 1));
        repeat (3) add(0, 4'b0100, own(2, 0));
        add(0, 4'b0100, own(2, 1));
        add(0, 4'b0100, own(2, 0));
        add(0, 4'b0000, '0);
        for (int k = 0; k < 17; k++) add(k == 0, 4'b1111, own((k / 4) % 4, k % 4 == 0));
        add(0, 4'b1010, own(1, 1));
        add(0, 4'b0000, '0);
        add(0, 4'b1010, own(3, 1));
        add(0, 4'b0010, own(1, 1));
        add(0, 4'b0000, '0);
        add(1, 4'b0001, own(0, 1));
        add(0, 4'b0111, own(0, 0));
        add(0, 4'b1101, own(0, 0));
        add(0, 4'b1001, own(0, 0));
        add(0, 4'b1001, own(3, 1));
        foreach (tbl[i]) begin
            if (tbl[i].pre_rst) do_reset();
            cycle(tbl[i].req, tbl[i].e, $sformatf("vec%0d", i));
        end
        do_reset();
        cycle(4'b0100, own(2, 1), "pre_async");
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back('0);
        check("async_rst");
        @(negedge clk);
        req = 4'b0101;
        @(posedge clk);
        #1;
        exp_q.push_back('0);
        check("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b0000;
        cycle(4'b0101, own(0, 1), "after_rst");
        do_reset();
        m_owner = -1;
        m_hold  = 0;
        m_last  = 3;
        r = 4'b0000;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            else r[$urandom_range(0, 3)] = 1'($urandom_range(0, 1));
            model(r, e);
            cycle(r, e, $sformatf("rand%0d", i));
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
